prog_loader: RTL

- Upstream instruction source for the accumulator CPU; replaces the fixed instruction ROM with a 16x8 writable program store.
- Accepts a program byte-stream over a valid/ready handshake.
- Serves combinational instruction fetch by PC.
- Gates the CPU with a run flag until loading completes.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/prog_ram.sv | 20 ++
 rtl/prog_loader.sv | 69 ++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU widths, opcodes and program-loader state encoding
package cpu_pkg;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN} ld_state_e;
endpackage

// File: rtl/prog_ram.sv
// prog_ram: register-array program store with sync write, sync clear and async read
module prog_ram #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (rst) mem <= '{default: '0};
    else if (we) mem[waddr] <= wdata;
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/prog_loader.sv
// prog_loader: streams a program into a writable store and gates the CPU until loading completes
module prog_loader import cpu_pkg::*; #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_instr,
  output logic              cpu_run,
  output logic [ADDR_W:0]   load_count,
  output logic              load_err
);
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH-1);
  ld_state_e state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [DATA_W-1:0] rdata;
  logic load_en_q, load_start, accept, enter;
  assign load_start = load_en & ~load_en_q;
  assign wr_ready = state == ST_LOAD;
  assign cpu_run = state == ST_RUN;
  assign accept = wr_valid & wr_ready;
  assign enter = state != ST_LOAD && state_nxt == ST_LOAD;
  always_comb begin
    state_nxt = state;
    state_nxt = state == ST_LOAD
      ? (((accept && load_count == LAST) || !load_en) ? ST_RUN : ST_LOAD)
      : (load_start ? ST_LOAD : state);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      wr_ptr <= '0;
      load_count <= '0;
      load_err <= 1'b0;
      load_en_q <= 1'b0;
    end else begin
      state <= state_nxt;
      load_en_q <= load_en;
      if (enter) begin
        wr_ptr <= '0;
        load_count <= '0;
        load_err <= 1'b0;
      end else begin
        if (accept) begin
          wr_ptr <= wr_ptr + ADDR_W'(1);
          load_count <= load_count + (ADDR_W+1)'(1);
        end
        if (wr_valid && state != ST_LOAD) load_err <= 1'b1;
      end
    end
  end
  prog_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk(clk),
    .rst(rst),
    .we(accept),
    .waddr(wr_ptr),
    .wdata(wr_data),
    .raddr(fetch_addr),
    .rdata(rdata)
  );
  // The CPU sees only no-ops until the program is complete.
  assign fetch_instr = cpu_run ? rdata : '0;
endmodule
